// File: rtl/operand_scoreboard.sv
// Operand supplier: architectural register file plus an in-order table of
// in-flight writers, with same-cycle result bypass into both read ports.
module operand_scoreboard #(
    parameter  int DEPTH = 4,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [4:0]    r1_addr,
    output logic          r1_valid,
    output logic [31:0]   r1_data,
    input  logic [4:0]    r2_addr,
    output logic          r2_valid,
    output logic [31:0]   r2_data,
    input  logic          issue_valid,
    input  logic [4:0]    issue_dest,
    output logic          issue_ready,
    output logic [TW-1:0] issue_tag,
    input  logic          res_valid,
    input  logic [TW-1:0] res_tag,
    input  logic [31:0]   res_data,
    input  logic          commit_valid,
    output logic [4:0]    commit_dest,
    output logic [31:0]   commit_data,
    output logic          head_done
);

    logic [TW:0]      r_head, r_tail;
    logic [DEPTH-1:0] r_busy, r_done;
    logic [4:0]       r_dest [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_rf   [32];

    logic [TW:0]      w_count, w_head_nxt;
    logic [TW-1:0]    w_head_idx, w_tail_idx;
    logic             w_empty, w_issue, w_result, w_commit;

    assign w_count    = r_tail - r_head;
    assign w_empty    = (w_count == '0);
    assign w_head_idx = r_head[TW-1:0];
    assign w_tail_idx = r_tail[TW-1:0];

    assign issue_ready = (w_count < (TW+1)'(DEPTH));
    assign issue_tag   = w_tail_idx;
    assign w_issue     = issue_valid && issue_ready && !flush;
    assign w_result    = res_valid && !flush && r_busy[res_tag];
    assign w_commit    = commit_valid && !w_empty;
    assign w_head_nxt  = w_commit ? r_head + (TW+1)'(1) : r_head;

    assign head_done   = !w_empty && r_done[w_head_idx];
    assign commit_dest = w_empty ? 5'd0  : r_dest[w_head_idx];
    assign commit_data = w_empty ? 32'd0 : r_data[w_head_idx];

    // Flush is applied last so it overrides issue/commit updates to busy and tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_busy <= '0;
            r_done <= '0;
        end else begin
            if (w_result)
                r_done[res_tag] <= 1'b1;
            if (w_issue) begin
                r_busy[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx] <= (issue_dest == 5'd0);
                r_tail             <= r_tail + (TW+1)'(1);
            end
            if (w_commit)
                r_busy[w_head_idx] <= 1'b0;
            r_head <= w_head_nxt;
            if (flush) begin
                r_busy <= '0;
                r_tail <= w_head_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue)
            r_dest[w_tail_idx] <= issue_dest;
        if (w_result)
            r_data[res_tag] <= res_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                r_rf[i] <= '0;
        end else if (w_commit && r_dest[w_head_idx] != 5'd0) begin
            r_rf[r_dest[w_head_idx]] <= r_data[w_head_idx];
        end
    end

    logic [4:0]  w_addr [2];
    logic        w_vld  [2];
    logic [31:0] w_rd   [2];

    assign w_addr[0] = r1_addr;
    assign w_addr[1] = r2_addr;
    assign r1_valid  = w_vld[0];
    assign r1_data   = w_rd[0];
    assign r2_valid  = w_vld[1];
    assign r2_data   = w_rd[1];

    // Walk oldest to youngest so the last hit is the newest writer.
    always_comb begin
        logic          w_hit, w_byp;
        logic [TW-1:0] w_m, w_e;
        for (int p = 0; p < 2; p++) begin
            w_hit = 1'b0;
            w_byp = 1'b0;
            w_m   = '0;
            w_e   = '0;
            for (int k = 0; k < DEPTH; k++) begin
                w_e = w_head_idx + TW'(k);
                if ((TW+1)'(k) < w_count && r_busy[w_e] && r_dest[w_e] == w_addr[p]) begin
                    w_hit = 1'b1;
                    w_m   = w_e;
                end
            end
            if (w_addr[p] == 5'd0) begin
                w_vld[p] = 1'b1;
                w_rd[p]  = 32'd0;
            end else if (w_hit) begin
                w_byp    = res_valid && (res_tag == w_m);
                w_vld[p] = r_done[w_m] || w_byp;
                w_rd[p]  = w_byp ? res_data : r_data[w_m];
            end else begin
                w_vld[p] = 1'b1;
                w_rd[p]  = r_rf[w_addr[p]];
            end
        end
    end

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench for operand_scoreboard (DEPTH=4) with hand-computed expectations.
module tb_operand_scoreboard;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [4:0]  r1_addr, r2_addr, issue_dest;
    logic        r1_valid, r2_valid, issue_valid, issue_ready;
    logic [31:0] r1_data, r2_data, res_data, commit_data;
    logic [1:0]  issue_tag, res_tag;
    logic        res_valid, commit_valid, head_done;
    logic [4:0]  commit_dest;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] dst  [4] = '{5'd10, 5'd11, 5'd12, 5'd8};
    logic [1:0] tags [4] = '{2'd3, 2'd0, 2'd1, 2'd2};

    always #5 clk = ~clk;

    operand_scoreboard #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .r1_addr(r1_addr), .r1_valid(r1_valid), .r1_data(r1_data),
        .r2_addr(r2_addr), .r2_valid(r2_valid), .r2_data(r2_data),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
        .commit_valid(commit_valid), .commit_dest(commit_dest),
        .commit_data(commit_data), .head_done(head_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; r1_addr = '0; r2_addr = '0;
        issue_valid = 1'b0; issue_dest = '0; res_valid = 1'b0; res_tag = '0;
        res_data = '0; commit_valid = 1'b0;
        #1 reset = 1'b0;
        r1_addr = 5'd5;
        #10;
        chk("rst_r1v", 32'(r1_valid), 1);
        chk("rst_r1d", r1_data, 0);
        chk("rst_ready", 32'(issue_ready), 1);
        chk("rst_tag", 32'(issue_tag), 0);
        chk("rst_hdone", 32'(head_done), 0);
        @(negedge clk) reset = 1'b1;

        // single writer, bypass, commit
        step();
        r1_addr = 5'd5; r2_addr = 5'd0;
        #1;
        chk("r5_init_v", 32'(r1_valid), 1);
        chk("r5_init_d", r1_data, 0);
        chk("r0_v", 32'(r2_valid), 1);
        chk("r0_d", r2_data, 0);
        issue_valid = 1'b1; issue_dest = 5'd5;
        step();
        issue_valid = 1'b0;
        #1;
        chk("r5_pend_v", 32'(r1_valid), 0);
        chk("tag_after1", 32'(issue_tag), 1);
        res_valid = 1'b1; res_tag = 2'd0; res_data = 32'h1234;
        #1;
        chk("r5_byp_v", 32'(r1_valid), 1);
        chk("r5_byp_d", r1_data, 32'h1234);
        step();
        res_valid = 1'b0;
        #1;
        chk("hdone1", 32'(head_done), 1);
        chk("cdest1", 32'(commit_dest), 5);
        chk("cdata1", commit_data, 32'h1234);
        commit_valid = 1'b1;
        step();
        commit_valid = 1'b0;
        #1;
        chk("r5_rf_v", 32'(r1_valid), 1);
        chk("r5_rf_d", r1_data, 32'h1234);
        chk("hdone_empty", 32'(head_done), 0);

        // two writers of r3, youngest wins
        r1_addr = 5'd3;
        issue_valid = 1'b1; issue_dest = 5'd3;
        #1 chk("r3_tagA", 32'(issue_tag), 1);
        step();
        chk("r3_tagB", 32'(issue_tag), 2);
        step();
        issue_valid = 1'b0;
        #1 chk("r3_pend_v", 32'(r1_valid), 0);
        res_valid = 1'b1; res_tag = 2'd2; res_data = 32'hB;
        #1;
        chk("r3_bypB_v", 32'(r1_valid), 1);
        chk("r3_bypB_d", r1_data, 32'hB);
        step();
        res_tag = 2'd1; res_data = 32'hA;
        #1 chk("r3_young_d", r1_data, 32'hB);
        step();
        res_valid = 1'b0; commit_valid = 1'b1;
        #1 chk("r3_cdataA", commit_data, 32'hA);
        step();
        chk("r3_cdataB", commit_data, 32'hB);
        step();
        commit_valid = 1'b0;
        #1;
        chk("r3_rf_d", r1_data, 32'hB);
        chk("r3_rf_v", 32'(r1_valid), 1);

        // fill, blocked issue with commit, pointer wrap
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_dest = dst[i];
            #1 chk("fill_tag", 32'(issue_tag), 32'(tags[i]));
            step();
        end
        issue_valid = 1'b0;
        #1;
        chk("full_ready", 32'(issue_ready), 0);
        res_valid = 1'b1; res_tag = 2'd3; res_data = 32'h10;
        step();
        res_valid = 1'b0; commit_valid = 1'b1; issue_valid = 1'b1; issue_dest = 5'd14;
        step();
        commit_valid = 1'b0; issue_valid = 1'b0;
        r1_addr = 5'd14; r2_addr = 5'd10;
        #1;
        chk("cnt3_ready", 32'(issue_ready), 1);
        chk("cnt3_tag", 32'(issue_tag), 3);
        chk("dropped_v", 32'(r1_valid), 1);
        chk("dropped_d", r1_data, 0);
        chk("r10_rf_d", r2_data, 32'h10);
        issue_valid = 1'b1; issue_dest = 5'd14;
        step();
        issue_valid = 1'b0;
        #1;
        chk("wrap_tag", 32'(issue_tag), 0);
        chk("wrap_full", 32'(issue_ready), 0);
        chk("r14_pend_v", 32'(r1_valid), 0);
        res_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_tag = 2'(i); res_data = 32'h20 + 32'(i);
            step();
        end
        res_valid = 1'b0; commit_valid = 1'b1;
        repeat (4) step();
        commit_valid = 1'b0; r2_addr = 5'd8;
        #1;
        chk("r14_rf_d", r1_data, 32'h23);
        chk("r8_rf_d", r2_data, 32'h22);
        chk("drain_ready", 32'(issue_ready), 1);
        chk("drain_tag", 32'(issue_tag), 0);
        chk("drain_hdone", 32'(head_done), 0);

        // flush together with commit
        r1_addr = 5'd7;
        issue_valid = 1'b1; issue_dest = 5'd7;
        step();
        issue_dest = 5'd8;
        step();
        issue_valid = 1'b0;
        res_valid = 1'b1; res_tag = 2'd0; res_data = 32'h77;
        #1 chk("r8_pend_v", 32'(r2_valid), 0);
        step();
        res_valid = 1'b0; commit_valid = 1'b1; flush = 1'b1;
        step();
        commit_valid = 1'b0; flush = 1'b0;
        #1;
        chk("fl_r7_v", 32'(r1_valid), 1);
        chk("fl_r7_d", r1_data, 32'h77);
        chk("fl_r8_v", 32'(r2_valid), 1);
        chk("fl_r8_d", r2_data, 32'h22);
        chk("fl_ready", 32'(issue_ready), 1);
        chk("fl_tag", 32'(issue_tag), 1);
        chk("fl_hdone", 32'(head_done), 0);
        res_valid = 1'b1; res_tag = 2'd1; res_data = 32'h99;
        #1 chk("fl_stale_byp", r2_data, 32'h22);
        step();
        res_valid = 1'b0;
        #1;
        chk("fl_stale_d", r2_data, 32'h22);
        chk("fl_stale_hd", 32'(head_done), 0);

        // asynchronous reset with three busy entries
        issue_valid = 1'b1;
        issue_dest = 5'd9;  step();
        issue_dest = 5'd20; step();
        issue_dest = 5'd21; step();
        issue_valid = 1'b0; r1_addr = 5'd9;
        #1;
        chk("b3_r9_v", 32'(r1_valid), 0);
        chk("b3_hdone", 32'(head_done), 0);
        reset = 1'b0;
        #1;
        chk("ar_r9_v", 32'(r1_valid), 1);
        chk("ar_r9_d", r1_data, 0);
        chk("ar_r8_d", r2_data, 0);
        chk("ar_ready", 32'(issue_ready), 1);
        chk("ar_tag", 32'(issue_tag), 0);
        chk("ar_cdest", 32'(commit_dest), 0);
        chk("ar_cdata", commit_data, 0);
        step();
        reset = 1'b1;
        step();
        chk("post_tag", 32'(issue_tag), 0);
        chk("post_ready", 32'(issue_ready), 1);
        chk("post_r9_v", 32'(r1_valid), 1);
        chk("post_hdone", 32'(head_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_scoreboard.md
# operand_scoreboard

Register-operand supplier for the read-operands stage. It holds the 32×32 architectural register file and an in-order table of issued-but-uncommitted writers. It answers the two operand read ports (`r1_*`, `r2_*`) with data plus a valid flag: the flag is low while the newest in-flight writer of that register has not yet produced its result. Execution units post results by tag, the commit stage pops the table into the register file, and flush discards everything uncommitted.

## Interface
Parameters:
- `DEPTH`, default 4: in-flight writer table entries; power of two, ≥2. `TW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `flush`  in  1  discard all uncommitted entries.
- `r1_addr`  in  5  operand 1 register index.
- `r1_valid`  out  1  operand 1 data available.
- `r1_data`  out  32  operand 1 value.
- `r2_addr`, `r2_valid`, `r2_data`  in/out/out  5/1/32  operand 2, identical to operand 1.
- `issue_valid`  in  1  read-operands instruction leaves the stage this cycle.
- `issue_dest`  in  5  destination register; 0 means no register write.
- `issue_ready`  out  1  table has a free entry.
- `issue_tag`  out  TW  tag allocated to the issuing instruction (tail index).
- `res_valid`  in  1  result delivery.
- `res_tag`  in  TW  entry receiving the result.
- `res_data`  in  32  result value.
- `commit_valid`  in  1  retire the head entry.
- `commit_dest`  out  5  head entry destination (trace).
- `commit_data`  out  32  head entry data (trace).
- `head_done`  out  1  table non-empty and head result present.

## Operation
- Entry fields: `busy`, `dest[4:0]`, `done`, `data[31:0]`. `head` and `tail` are TW+1-bit pointers. `count = tail - head`, modulo 2^(TW+1).
- Issue: when `issue_valid && issue_ready && !flush`, the entry at `tail` is set to `busy=1`, `dest=issue_dest`, `done=(issue_dest==0)`, and `tail` increments. `issue_tag = tail[TW-1:0]` (combinational).
- Result: when `res_valid && !flush` and the entry at `res_tag` is `busy`, it sets `done=1` and `data=res_data`. A result to a non-busy entry is ignored. A second result to a done entry overwrites its data.
- Operand lookup (combinational, per port):
  - `addr==0`: valid=1, data=0.
  - Otherwise, search the busy entries from youngest to oldest for `dest==addr`.
  - If a match is found: valid = `done` OR (`res_valid && res_tag==match`); data = the same-cycle `res_data` when that bypass applies, else the entry `data`.
  - If no match: valid=1, data = register file.
- Commit: when `commit_valid`, the head entry's `data` is written to `rf[dest]` if `dest!=0`. The entry's `busy` is cleared and `head` increments. Precondition: `head_done==1`. A commit with an empty table is ignored.
- Flush: at the edge, all entries get `busy=0` and `tail` is set to the post-commit `head`. Same-cycle issue and result are dropped. A same-cycle commit is still performed first.
- `issue_ready = (count < DEPTH)`. It is computed from registered state only and does not look ahead to a same-cycle commit.
- `rf[0]` is never written and always reads 0.

## Timing
- Reset (asynchronous, level 0): all `rf` = 0, every `busy` = 0, `head` = `tail` = 0.
  - Outputs while in reset: `issue_ready=1`, `issue_tag=0`, `head_done=0`, `commit_dest=0`, `commit_data=0`.
  - `r*_valid=1`, `r*_data=0`.
- Reset mid-operation discards all in-flight entries; the register file clears to 0.
- Operand outputs are purely combinational from `r*_addr`, the table, the register file and the result port. Zero latency.
- Issue becomes visible to lookups on the cycle after `issue_valid`.
- A result is visible in the cycle it is presented (bypass) and from the table afterward.
- After a commit, the register file holds the value from the next cycle. The lookup value is continuous across the commit: the entry is removed on the same edge.
- Full table: `issue_ready=0`, and an issue in that cycle is ignored even if a commit occurs in the same cycle.
- Pointer wrap: pointers wrap modulo 2^(TW+1); the table is full when `count == DEPTH`.

## Test plan
- Reset, then read r5 and r0 → `r1_valid=1`, `r1_data=0`; `issue_ready=1`, `issue_tag=0`.
- Issue dest=5 (tag 0), then read r5 → `valid=0`. Present `res_tag=0`, `res_data=0x1234` → same-cycle `valid=1`, data `0x1234`. Commit → `rf[5]=0x1234` on the next cycle and the lookup is unchanged.
- Issue dest=3 twice (tags 0 and 1). Give tag 1 the result `0xB` and tag 0 the result `0xA` → r3 reads `0xB` (youngest). Commit both → `rf[3]=0xB`.
- Issue 4 entries (DEPTH=4) → `issue_ready=0`. An issue plus a commit in the same cycle → that issue is dropped and `count=3`. Continue until the pointers wrap past 7 → tags cycle 0..3 correctly.
- Issue dest=7 and dest=8, then flush together with a commit of the head → `rf[7]` is written, the dest=8 entry is discarded, r8 reads the old value with `valid=1`, and a later `res_tag` pointing at the discarded entry is ignored.
- Drive `reset=0` with 3 busy entries → all outputs return to reset values immediately; releasing reset leaves the table empty.
